// File: rtl/pw_sniff_pkg.sv
// Shared types and constants for the sniff capture buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pw_sniff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Bit positions inside the status byte
    localparam int ST_EMPTY_BIT    = 0;
    localparam int ST_UNDERFLOW_BIT = 1;
    localparam int ST_PEMPTY_BIT   = 2;
    localparam int ST_FULL_BIT     = 3;
    localparam int ST_OVERFLOW_BIT = 4;
    localparam int ST_PFULL_BIT    = 5;
    localparam int ST_ACTIVE_BIT   = 6;
    localparam int ST_DONE_BIT     = 7;

    // Bytes per serialised record: data bytes rounded up, plus one status byte
    function automatic int rec_bytes(input int data_width);
        return (data_width + 7) / 8 + 1;
    endfunction

endpackage

// File: rtl/pw_sniff_buffer_if.sv
// Capture/readout bus of the sniff buffer; master drives, slave is the buffer.
// Latency: n/a (wiring only).
// Backpressure: none; writes beyond capacity are dropped and flagged by the buffer.
interface pw_sniff_buffer_if #(
    parameter int pDATA_WIDTH = 18,
    parameter int pDEPTH_LOG2 = 11
);
    logic                   arm_i;
    logic                   wr_en_i;
    logic [pDATA_WIDTH-1:0] wr_data_i;
    logic [15:0]            capture_len_i;
    logic [pDEPTH_LOG2:0]   prog_full_thresh_i;
    logic [pDEPTH_LOG2:0]   prog_empty_thresh_i;
    logic                   rd_i;
    logic [15:0]            rd_bytecnt_i;
    logic [7:0]             rd_data_o;
    logic [7:0]             status_o;
    logic [pDEPTH_LOG2:0]   count_o;
    logic                   capture_active_o;
    logic                   capture_done_o;
    logic                   fifo_full_o;
    logic [pDEPTH_LOG2:0]   hwm_o;

    modport master (
        output arm_i, wr_en_i, wr_data_i, capture_len_i,
               prog_full_thresh_i, prog_empty_thresh_i, rd_i, rd_bytecnt_i,
        input  rd_data_o, status_o, count_o, capture_active_o,
               capture_done_o, fifo_full_o, hwm_o
    );

    modport slave (
        input  arm_i, wr_en_i, wr_data_i, capture_len_i,
               prog_full_thresh_i, prog_empty_thresh_i, rd_i, rd_bytecnt_i,
        output rd_data_o, status_o, count_o, capture_active_o,
               capture_done_o, fifo_full_o, hwm_o
    );
endinterface

// File: rtl/pw_sync_fifo.sv
// Single-clock RAM FIFO with registered read data and synchronous clear.
// Latency: pop data appears on rd_dat_o one cycle after rd_i.
// Backpressure: writes while full and reads while empty are ignored; clear wins over both.
module pw_sync_fifo #(
    parameter int W  = 18,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [W-1:0]  wr_dat_i,
    input  logic          rd_i,
    output logic [W-1:0]  rd_dat_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [1 << AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  rd_dat_q, rd_dat_d;
    logic          wr_acc, rd_acc;

    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == '0);
    assign wr_acc   = wr_i && !full_o;
    assign rd_acc   = rd_i && !empty_o;
    assign rd_dat_o = rd_dat_q;
    assign count_o  = count_q;

    // Next pointers/count; pointers wrap naturally at the depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rd_dat_d = rd_acc ? mem[rd_ptr_q] : rd_dat_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_dat_i;
    end

    // Pointer, count and read-data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_dat_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_dat_q <= rd_dat_d;
        end
    end

endmodule

// File: rtl/pw_sniff_buffer.sv
// Sniff capture buffer: arm/flush/capture/done control over a FIFO, byte-serialised readout. Option macro: PW_SNIFF_HWM_EN.
// Latency: rd_data_o valid the cycle after rd_i; a popped record is visible on that same byte.
// Backpressure: none; writes while full set sticky overflow, b=0 reads while empty set sticky underflow.
module pw_sniff_buffer
    import pw_sniff_pkg::*;
#(
    parameter int pDATA_WIDTH = 18,
    parameter int pDEPTH_LOG2 = 11
) (
    input  logic             cwusb_clk,
    input  logic             reset_n,
    pw_sniff_buffer_if.slave bus
);
    localparam int pREC_BYTES = rec_bytes(pDATA_WIDTH);
    localparam int BW         = $clog2(pREC_BYTES);
    localparam int PADW       = 8 << BW;
    localparam logic [BW-1:0] LAST_B = BW'(pREC_BYTES - 1);

    state_e                 state_q, state_d;
    logic [15:0]            rec_cnt_q, rec_cnt_d, rec_cnt_inc;
    logic                   unf_q, unf_d, ovf_q, ovf_d;
    logic                   hold_vld_q, hold_vld_d, rd_vld_q, rd_vld_d;
    logic [BW-1:0]          rd_b_q, rd_b_d, b;
    logic [7:0]             snap_q, snap_d, status;
    logic [pDATA_WIDTH-1:0] hold_dat;
    logic [PADW-1:0]        hold_pad;
    logic [pDEPTH_LOG2:0]   count;
    logic                   full, empty, flush, wr_acc, rd_b0, pop;

    assign b        = BW'(bus.rd_bytecnt_i % 16'(pREC_BYTES));
    assign flush    = (state_q == ST_FLUSH);
    assign wr_acc   = (state_q == ST_CAPTURE) && !bus.arm_i && bus.wr_en_i && !full;
    assign rd_b0    = bus.rd_i && (b == '0);
    assign pop      = rd_b0 && !empty;
    assign hold_pad = PADW'(hold_dat);

    pw_sync_fifo #(.W(pDATA_WIDTH), .AW(pDEPTH_LOG2)) u_fifo (
        .clk      (cwusb_clk),
        .rst_n    (reset_n),
        .clr_i    (flush),
        .wr_i     (wr_acc),
        .wr_dat_i (bus.wr_data_i),
        .rd_i     (pop),
        .rd_dat_o (hold_dat),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Live status byte; thresholds act combinationally
    always_comb begin
        status                   = '0;
        status[ST_EMPTY_BIT]     = empty;
        status[ST_UNDERFLOW_BIT] = unf_q;
        status[ST_PEMPTY_BIT]    = !empty && (count <= bus.prog_empty_thresh_i);
        status[ST_FULL_BIT]      = full;
        status[ST_OVERFLOW_BIT]  = ovf_q;
        status[ST_PFULL_BIT]     = (count >= bus.prog_full_thresh_i);
        status[ST_ACTIVE_BIT]    = (state_q == ST_CAPTURE);
        status[ST_DONE_BIT]      = (state_q == ST_DONE);
    end

    // Capture state machine and record counter; arm overrides everything
    always_comb begin
        state_d     = state_q;
        rec_cnt_inc = (rec_cnt_q == 16'hFFFF) ? rec_cnt_q : rec_cnt_q + 16'd1;
        rec_cnt_d   = rec_cnt_q;
        if (flush)       rec_cnt_d = '0;
        else if (wr_acc) rec_cnt_d = rec_cnt_inc;
        if (bus.arm_i) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_FLUSH:   state_d = ST_CAPTURE;
                ST_CAPTURE: if (wr_acc && bus.capture_len_i != 16'd0 &&
                                rec_cnt_inc == bus.capture_len_i) state_d = ST_DONE;
                default:    state_d = state_q;
            endcase
        end
    end

    // Sticky flags and read-side bookkeeping for the following cycle's byte
    always_comb begin
        unf_d      = flush ? 1'b0 : (unf_q || (rd_b0 && empty));
        ovf_d      = flush ? 1'b0 : (ovf_q || ((state_q == ST_CAPTURE) && !bus.arm_i &&
                                               bus.wr_en_i && full));
        hold_vld_d = rd_b0 ? !empty : hold_vld_q;
        rd_vld_d   = bus.rd_i;
        rd_b_d     = b;
        snap_d     = status;
    end

    // State and flag registers
    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rec_cnt_q  <= '0;
            unf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            hold_vld_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_b_q     <= '0;
            snap_q     <= '0;
        end else begin
            state_q    <= state_d;
            rec_cnt_q  <= rec_cnt_d;
            unf_q      <= unf_d;
            ovf_q      <= ovf_d;
            hold_vld_q <= hold_vld_d;
            rd_vld_q   <= rd_vld_d;
            rd_b_q     <= rd_b_d;
            snap_q     <= snap_d;
        end
    end

    // Byte mux: status byte last, data bytes zero after an underflowed pop
    always_comb begin
        bus.rd_data_o = '0;
        if (rd_vld_q) begin
            if (rd_b_q == LAST_B) bus.rd_data_o = snap_q;
            else if (hold_vld_q)  bus.rd_data_o = hold_pad[{rd_b_q, 3'b000} +: 8];
        end
    end

    assign bus.status_o         = status;
    assign bus.count_o          = count;
    assign bus.capture_active_o = (state_q == ST_CAPTURE);
    assign bus.capture_done_o   = (state_q == ST_DONE);
    assign bus.fifo_full_o      = full;

`ifdef PW_SNIFF_HWM_EN
    logic [pDEPTH_LOG2:0] hwm_q, hwm_d;

    // Peak occupancy since the last flush
    always_comb begin
        hwm_d = flush ? '0 : ((count > hwm_q) ? count : hwm_q);
    end

    // High-water mark register
    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) hwm_q <= '0;
        else          hwm_q <= hwm_d;
    end

    assign bus.hwm_o = hwm_q;
`else
    assign bus.hwm_o = '0;
`endif

endmodule

// File: doc/pw_sniff_buffer.md
Name: pw_sniff_buffer

Overview:
Single-clock successor to the dual-clock sniff FIFO path. Buffers front-end capture records of parametrised width and depth behind an arm/flush/capture/done state machine. Enforces a runtime capture length, keeps sticky overflow/underflow flags and runtime-programmable thresholds. Serialises each record into byte-wide register reads, with a trailing status byte.

Parameters:
pDATA_WIDTH, 18, record width in bits (1..56).
pDEPTH_LOG2, 11, FIFO depth = 2**pDEPTH_LOG2 records.
pREC_BYTES, derived = ceil(pDATA_WIDTH/8)+1, bytes per record read including status byte (localparam).

Ports:
cwusb_clk  in  1  sole clock.
reset_n  in  1  asynchronous, active-low reset.
arm_i  in  1  one-cycle pulse: flush and start capture.
wr_en_i  in  1  record write strobe.
wr_data_i  in  pDATA_WIDTH  record.
capture_len_i  in  16  records to accept per capture; 0 = unlimited.
prog_full_thresh_i  in  pDEPTH_LOG2+1  prog_full asserted when count >= value.
prog_empty_thresh_i  in  pDEPTH_LOG2+1  prog_empty asserted when 0 < count <= value.
rd_i  in  1  byte read strobe (register read qualified by address).
rd_bytecnt_i  in  16  register byte counter.
rd_data_o  out  8  read byte, valid the cycle after rd_i.
status_o  out  8  live status byte.
count_o  out  pDEPTH_LOG2+1  occupancy.
capture_active_o  out  1  state == CAPTURE.
capture_done_o  out  1  state == DONE.
fifo_full_o  out  1  count == depth.
hwm_o  out  pDEPTH_LOG2+1  high-water mark (optional feature).

Behaviour:
- Reset (async, reset_n low): state IDLE; pointers, count, record counter and sticky flags are 0; all outputs are 0 except status_o, whose empty bit is 1.
- States:
  - IDLE: writes dropped silently. arm_i -> FLUSH.
  - FLUSH, exactly 1 cycle: pointers, count, record counter, overflow and underflow cleared -> CAPTURE.
  - CAPTURE: a write is accepted when wr_en_i=1 and not full; record counter increments. When capture_len_i != 0 and the accepted write makes the counter equal capture_len_i -> DONE on the next cycle.
  - DONE: writes dropped silently; reads continue. arm_i -> FLUSH.
- arm_i in any state, including FLUSH and mid-CAPTURE, -> FLUSH. Unread data is discarded. arm_i has priority over a same-cycle write, which is dropped.
- Full: wr_en_i while full in CAPTURE sets overflow sticky and drops the record. Full is evaluated on the pre-cycle count: a same-cycle pop does not admit the write.
- Record counter saturates at 0xFFFF (unlimited mode).
- Read serialisation: byte index b = rd_bytecnt_i mod pREC_BYTES.
  - b=0 pops one record into a holding register if not empty.
  - b<pREC_BYTES-1 returns holding[8b +: 8], zero-padded above pDATA_WIDTH.
  - b=pREC_BYTES-1 returns status_o sampled at the rd_i cycle.
  - rd_data_o is 0 in cycles following no rd_i.
- Empty: b=0 read while empty sets underflow sticky. The holding register is unchanged; data bytes read as 0 for that record. There is no write-to-read bypass: a simultaneous write and b=0 read on an empty FIFO underflows.
- Simultaneous accepted write and pop: count unchanged. Pointers wrap modulo depth.
- status_o bits:
  - [0] empty
  - [1] underflow sticky
  - [2] prog_empty
  - [3] full
  - [4] overflow sticky
  - [5] prog_full
  - [6] capture_active
  - [7] capture_done
- Thresholds are sampled live; changing them takes effect the same cycle on status.

Optional Feature:
PW_SNIFF_HWM_EN:
- Defined: hwm_o tracks the maximum count since the last FLUSH (cleared in FLUSH, updated every cycle).
- Undefined: hwm_o is tied to 0 and no HWM logic is synthesised.

Decomposition:
- Package pw_sniff_pkg:
  - state enum (IDLE, FLUSH, CAPTURE, DONE);
  - status bit index constants;
  - pREC_BYTES computation function.
- Sub-module pw_sync_fifo: single-clock RAM FIFO with registered read data, count, full/empty, synchronous clear input.
- The state machine, serialiser and sticky flags stay in the top module.

Test Plan:
1. Reset, arm, capture_len=4, write 6 records 0x00001..0x00006 -> 4 accepted, count=4, capture_done_o=1; the 2 extra writes are dropped with overflow=0.
2. pDATA_WIDTH=18 (pREC_BYTES=4): read bytecnt 0..3 after writing 0x2ABCD -> bytes 0xCD, 0xAB, 0x02, then a status byte with empty bit = 1.
3. capture_len=0, pDEPTH_LOG2=4: write 17 records -> fifo_full_o=1, overflow bit [4]=1, count=16. Then arm -> one FLUSH cycle; count=0, status=0x41.
4. Read b=0 on an empty FIFO -> underflow bit [1]=1, data bytes 0. A concurrent write is not returned and count becomes 1.
5. prog_full_thresh=3, prog_empty_thresh=1: counts 0/1/2/3 -> status [2]/[5] = 0/0, 1/0, 0/0, 0/1.
6. reset_n low mid-CAPTURE with count=5 -> immediate IDLE, count=0, status=0x01. With PW_SNIFF_HWM_EN, hwm_o=0 after reset and peaks at 5 before it.
